// File: rtl/wb_arbiter.sv
// Write-back port arbiter: shares the single register-file write port between the
// memory stage and the multiplier, queueing losing multiplier results in a small FIFO.
module wb_arbiter #(
  parameter int ARCH_LEN     = 32,
  parameter int REG_W        = 5,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_valid,
  input  logic                mem_we,
  input  logic [REG_W-1:0]    mem_rd,
  input  logic [ARCH_LEN-1:0] mem_data,
  output logic                mem_stall,
  input  logic                mul_valid,
  input  logic [REG_W-1:0]    mul_rd,
  input  logic [ARCH_LEN-1:0] mul_data,
  output logic                mul_stall,
  output logic                wb_valid,
  output logic [REG_W-1:0]    wb_rd,
  output logic [ARCH_LEN-1:0] wb_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SW    = $clog2(STARVE_LIMIT + 1);

  logic [REG_W-1:0]    fifo_rd   [DEPTH];
  logic [ARCH_LEN-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [PTR_W:0]      count;
  logic [SW-1:0]       starve_cnt;
  logic                mul_stall_q;

  logic             mem_req, inc_ok, conflict, fifo_nonempty;
  logic             grant_mem, grant_mul, push, pop;
  logic [PTR_W-1:0] off [DEPTH];

  assign mem_req       = mem_valid & mem_we & (mem_rd != '0);
  assign inc_ok        = mul_valid & ~mul_stall_q & (mul_rd != '0);
  assign fifo_nonempty = (count != '0);

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    conflict = inc_ok & (mul_rd == mem_rd);
    for (int i = 0; i < DEPTH; i++) begin
      off[i] = PTR_W'(i) - rd_ptr;
      if (({1'b0, off[i]} < count) && (fifo_rd[i] == mem_rd))
        conflict = 1'b1;
    end
  end

  assign grant_mem = mem_req & ~conflict & (starve_cnt < SW'(STARVE_LIMIT));
  assign grant_mul = ~grant_mem & (fifo_nonempty | inc_ok);
  assign pop       = grant_mul & fifo_nonempty;
  assign push      = inc_ok & ~(grant_mul & ~fifo_nonempty);

  assign mem_stall = rst_n & mem_req & ~grant_mem;
  assign mul_stall = mul_stall_q;

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_rd[wr_ptr]   <= mul_rd;
      fifo_data[wr_ptr] <= mul_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      starve_cnt  <= '0;
      mul_stall_q <= 1'b1;
    end else begin
      wb_valid <= grant_mem | grant_mul;
      if (grant_mem) begin
        wb_rd   <= mem_rd;
        wb_data <= mem_data;
      end else if (pop) begin
        wb_rd   <= fifo_rd[rd_ptr];
        wb_data <= fifo_data[rd_ptr];
      end else if (grant_mul) begin
        wb_rd   <= mul_rd;
        wb_data <= mul_data;
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      mul_stall_q <= (push & ~pop & (count == (PTR_W+1)'(DEPTH - 1))) |
                     (~push & ~pop & (count == (PTR_W+1)'(DEPTH)));

      if (grant_mul || !fifo_nonempty)
        starve_cnt <= '0;
      else if (grant_mem && starve_cnt < SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: per-cycle directed vectors with hand-computed write-back
// expectations, plus reset sequences around them.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_we, mul_valid;
  logic [4:0]  mem_rd, mul_rd;
  logic [31:0] mem_data, mul_data;
  logic        mem_stall, mul_stall, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.ARCH_LEN(32), .REG_W(5), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
    .mem_stall(mem_stall),
    .mul_valid(mul_valid), .mul_rd(mul_rd), .mul_data(mul_data),
    .mul_stall(mul_stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  typedef struct {
    logic        mv, mwe;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        uv;
    logic [4:0]  urd;
    logic [31:0] ud;
    logic        ems, emus, ewv;
    logic [4:0]  erd;
    logic [31:0] ed;
  } vec_t;

  localparam int NV = 40;
  vec_t vecs [NV];

  function automatic vec_t v(logic mv, logic mwe, logic [4:0] mrd, logic [31:0] md,
                             logic uv, logic [4:0] urd, logic [31:0] ud,
                             logic ems, logic emus, logic ewv, logic [4:0] erd,
                             logic [31:0] ed);
    vec_t r;
    r.mv = mv; r.mwe = mwe; r.mrd = mrd; r.md = md;
    r.uv = uv; r.urd = urd; r.ud = ud;
    r.ems = ems; r.emus = emus; r.ewv = ewv; r.erd = erd; r.ed = ed;
    return r;
  endfunction

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic drive(input logic mv, input logic mwe, input logic [4:0] mrd,
                       input logic [31:0] md, input logic uv, input logic [4:0] urd,
                       input logic [31:0] ud);
    mem_valid = mv; mem_we = mwe; mem_rd = mrd; mem_data = md;
    mul_valid = uv; mul_rd = urd; mul_data = ud;
  endtask

  initial begin
    vecs[0]  = v(1,1, 5,32'hAAAA, 1, 6,32'h1234, 0,0, 0, 0,0);
    vecs[1]  = v(0,0, 0,0,        0, 0,0,        0,0, 1, 5,32'hAAAA);
    vecs[2]  = v(0,0, 0,0,        0, 0,0,        0,0, 1, 6,32'h1234);
    vecs[3]  = v(0,0, 0,0,        0, 0,0,        0,0, 0, 0,0);
    vecs[4]  = v(1,1, 1,32'h100,  1, 7,32'h11,   0,0, 0, 0,0);
    vecs[5]  = v(1,1, 2,32'h200,  0, 0,0,        0,0, 1, 1,32'h100);
    vecs[6]  = v(1,1, 7,32'h22,   0, 0,0,        1,0, 1, 2,32'h200);
    vecs[7]  = v(1,1, 7,32'h22,   0, 0,0,        0,0, 1, 7,32'h11);
    vecs[8]  = v(0,0, 0,0,        0, 0,0,        0,0, 1, 7,32'h22);
    vecs[9]  = v(0,0, 0,0,        0, 0,0,        0,0, 0, 0,0);
    vecs[10] = v(1,1, 1,32'hA1,   1, 8,32'h81,   0,0, 0, 0,0);
    vecs[11] = v(1,1, 2,32'hA2,   1, 9,32'h91,   0,0, 1, 1,32'hA1);
    vecs[12] = v(1,1, 3,32'hA3,   1,10,32'hA0,   0,1, 1, 2,32'hA2);
    vecs[13] = v(1,1, 4,32'hA4,   1,10,32'hA0,   0,1, 1, 3,32'hA3);
    vecs[14] = v(1,1, 5,32'hA5,   1,10,32'hA0,   0,1, 1, 4,32'hA4);
    vecs[15] = v(1,1, 6,32'hA6,   1,10,32'hA0,   1,1, 1, 5,32'hA5);
    vecs[16] = v(1,1, 6,32'hA6,   1,10,32'hA0,   0,0, 1, 8,32'h81);
    vecs[17] = v(0,0, 0,0,        0, 0,0,        0,1, 1, 6,32'hA6);
    vecs[18] = v(0,0, 0,0,        0, 0,0,        0,0, 1, 9,32'h91);
    vecs[19] = v(0,0, 0,0,        0, 0,0,        0,0, 1,10,32'hA0);
    vecs[20] = v(0,0, 0,0,        0, 0,0,        0,0, 0, 0,0);
    vecs[21] = v(1,0, 3,32'h33,   1, 0,32'h44,   0,0, 0, 0,0);
    vecs[22] = v(1,1, 0,32'h55,   1, 0,32'h66,   0,0, 0, 0,0);
    vecs[23] = v(0,0, 0,0,        0, 0,0,        0,0, 0, 0,0);
    vecs[24] = v(0,0, 0,0,        1,11,32'hB,    0,0, 0, 0,0);
    vecs[25] = v(0,0, 0,0,        0, 0,0,        0,0, 1,11,32'hB);
    vecs[26] = v(0,0, 0,0,        0, 0,0,        0,0, 0, 0,0);
    vecs[27] = v(1,1,12,32'hC1,   1,12,32'hC2,   1,0, 0, 0,0);
    vecs[28] = v(1,1,12,32'hC1,   0, 0,0,        0,0, 1,12,32'hC2);
    vecs[29] = v(0,0, 0,0,        0, 0,0,        0,0, 1,12,32'hC1);
    vecs[30] = v(0,0, 0,0,        0, 0,0,        0,0, 0, 0,0);
    vecs[31] = v(1,1, 1,32'h51,   1,13,32'hD,    0,0, 0, 0,0);
    vecs[32] = v(1,1, 2,32'h52,   0, 0,0,        0,0, 1, 1,32'h51);
    vecs[33] = v(1,1, 3,32'h53,   0, 0,0,        0,0, 1, 2,32'h52);
    vecs[34] = v(1,1, 4,32'h54,   0, 0,0,        0,0, 1, 3,32'h53);
    vecs[35] = v(1,1, 5,32'h55,   0, 0,0,        0,0, 1, 4,32'h54);
    vecs[36] = v(1,1, 6,32'h56,   0, 0,0,        1,0, 1, 5,32'h55);
    vecs[37] = v(1,1, 6,32'h56,   0, 0,0,        0,0, 1,13,32'hD);
    vecs[38] = v(0,0, 0,0,        0, 0,0,        0,0, 1, 6,32'h56);
    vecs[39] = v(0,0, 0,0,        0, 0,0,        0,0, 0, 0,0);

    // Reset held with both requesters active.
    rst_n = 1'b0;
    drive(1,1, 5,32'hDEAD, 1, 6,32'hBEEF);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_wb_valid", i, wb_valid, 1'b0);
      chk("rst_mul_stall", i, mul_stall, 1'b1);
      chk("rst_mem_stall", i, mem_stall, 1'b0);
    end
    chk("rst_wb_rd", 0, wb_rd, 5'd0);
    chk("rst_wb_data", 0, wb_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0,0,0,0,0,0,0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel_mul_stall", 0, mul_stall, 1'b0);
    chk("rel_wb_valid", 0, wb_valid, 1'b0);
    @(posedge clk); #1;

    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].mv, vecs[k].mwe, vecs[k].mrd, vecs[k].md,
            vecs[k].uv, vecs[k].urd, vecs[k].ud);
      @(negedge clk);
      chk("mem_stall", k, mem_stall, vecs[k].ems);
      chk("mul_stall", k, mul_stall, vecs[k].emus);
      chk("wb_valid", k, wb_valid, vecs[k].ewv);
      if (vecs[k].ewv) begin
        chk("wb_rd", k, wb_rd, vecs[k].erd);
        chk("wb_data", k, wb_data, vecs[k].ed);
      end
      @(posedge clk); #1;
    end

    // Fill the FIFO, then reset mid-operation: queued results must vanish.
    drive(1,1, 1,32'hE1, 1, 8,32'hF8);
    @(posedge clk); #1;
    drive(1,1, 2,32'hE2, 1, 9,32'hF9);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_full", 0, mul_stall, 1'b1);
    rst_n = 1'b0;
    drive(1,1, 3,32'hE3, 1,10,32'hFA);
    @(negedge clk);
    chk("mid_rst_mem_stall", 0, mem_stall, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_wb_valid", 0, wb_valid, 1'b0);
    chk("mid_rst_mul_stall", 0, mul_stall, 1'b1);
    chk("mid_rst_mem_stall", 1, mem_stall, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0,0,0,0,0,0,0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_rst_wb_valid", i, wb_valid, 1'b0);
      chk("post_rst_mul_stall", i, mul_stall, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
